uart_word_tx: RTL

//  Parametrised UART transmitter for the miner result path. Queues WORD_W-bit

---
 rtl/uart_word_tx_if.sv | 26 ++
 rtl/uart_word_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx_if.sv
// Word-queue / serial-line bundle for uart_word_tx.
// master drives words and transmit requests; slave is the transmitter.
interface uart_word_tx_if #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_W-1:0] word_in;
    logic              word_we;
    logic              transmit_data;
    logic              txd;
    logic              busy;
    logic [CNT_W-1:0]  fifo_count;
    logic              error;

    modport master (
        output word_in, word_we, transmit_data,
        input  txd, busy, fifo_count, error
    );

    modport slave (
        input  word_in, word_we, transmit_data,
        output txd, busy, fifo_count, error
    );
endinterface

// File: rtl/uart_word_tx.sv
// Queued multi-byte UART transmitter (8N1, or 8x1 with parity).
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic clock,
    input  logic reset,
    uart_word_tx_if.slave bus
);
    localparam int BYTES  = WORD_W / 8;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2 || WORD_W < 8 || (WORD_W % 8) != 0 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        MSB_FIRST < 0 || MSB_FIRST > 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_word_tx: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t state_q, state_d;

    logic              busy_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [BIDX_W-1:0] byte_q;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              error_q;

    logic              tick, pop, push, full, overflow;
    logic              last_byte, start_drain, end_drain;
    logic [BIDX_W-1:0] sel;
    logic [7:0]        cur_byte;
    logic              txd_c;

    assign tick      = baud_q == BAUD_W'(CLKS_PER_BIT - 1);
    assign full      = count_q == CNT_W'(FIFO_DEPTH);
    assign pop       = state_q == S_LOAD;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push      = bus.word_we && (!full || pop);
    assign overflow  = bus.word_we && full && !pop;
    assign last_byte = byte_q == BIDX_W'(BYTES - 1);

    assign sel      = (MSB_FIRST != 0) ? BIDX_W'(BYTES - 1) - byte_q : byte_q;
    assign cur_byte = 8'(word_q >> {sel, 3'b000});

    always_comb begin
        state_d     = state_q;
        start_drain = 1'b0;
        end_drain   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (busy_q) begin
                    state_d = S_LOAD;
                end else if (bus.transmit_data && count_q != '0) begin
                    start_drain = 1'b1;
                end
            end
            S_LOAD: state_d = S_START;
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick && bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (!last_byte) begin
                        state_d = S_START;
                    end else if (count_q != '0) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d   = S_IDLE;
                        end_drain = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        txd_c = 1'b1;
        case (state_q)
            S_START:  txd_c = 1'b0;
            S_DATA:   txd_c = cur_byte[bit_q];
`ifdef UART_PARITY_EN
            S_PARITY: txd_c = (^cur_byte) ^ (PARITY_ODD != 0);
`endif
            default:  txd_c = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.word_in;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_drain)    busy_q <= 1'b1;
            else if (end_drain) busy_q <= 1'b0;

            // IDLE and LOAD hold the counter at 0 so START always gets a full bit.
            if (tick || state_q == S_IDLE || state_q == S_LOAD)
                baud_q <= '0;
            else
                baud_q <= baud_q + 1'b1;

            if (state_q == S_DATA && tick) bit_q <= bit_q + 1'b1;

            if (pop)
                byte_q <= '0;
            else if (state_q == S_STOP && tick && !last_byte)
                byte_q <= byte_q + 1'b1;

            if (pop) begin
                word_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (overflow) error_q <= 1'b1;
        end
    end

    assign bus.txd        = txd_c;
    assign bus.busy       = busy_q;
    assign bus.fifo_count = count_q;
    assign bus.error      = error_q;
endmodule
